pnl_tracker: RTL and testbench



---
 rtl/pnl_tracker_if.sv | 24 ++
 rtl/pnl_tracker.sv | 160 ++++++++++++++++
 tb/tb_pnl_tracker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pnl_tracker_if.sv
// Fill-report and mark-price feed into the P&L tracker.
// The venue adapter drives the master side; the tracker is the slave.
interface pnl_tracker_if #(
  parameter int QTY_W = 32,
  parameter int PX_W  = 32
);
  logic             fill_valid;
  logic             fill_ready;
  logic             fill_side;
  logic [QTY_W-1:0] fill_qty;
  logic [PX_W-1:0]  fill_price;
  logic             mark_valid;
  logic [PX_W-1:0]  mark_price;

  modport master (
    output fill_valid, fill_side, fill_qty, fill_price, mark_valid, mark_price,
    input  fill_ready
  );

  modport slave (
    input  fill_valid, fill_side, fill_qty, fill_price, mark_valid, mark_price,
    output fill_ready
  );
endinterface

// File: rtl/pnl_tracker.sv
// Streaming mark-to-market P&L tracker: fills -> notional -> cash/position -> mtm -> P&L.
// Feeds loss magnitude/flag to the kill switch, plus drawdown and status.
module pnl_tracker #(
  parameter int QTY_W = 32,
  parameter int PX_W  = 32,
  parameter int PNL_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  pnl_tracker_if.slave      feed,
  input  logic              cmd_clear,
  output logic [PNL_W-1:0]  current_pnl,
  output logic              pnl_is_loss,
  output logic [PNL_W-1:0]  pnl_signed,
  output logic [PNL_W-1:0]  drawdown,
  output logic [QTY_W-1:0]  position,
  output logic [31:0]       fill_count,
  output logic              pos_saturated
);
  localparam int PRW = QTY_W + PX_W;
  localparam int CW  = (PRW > PNL_W) ? PRW : PNL_W;
  localparam int MW  = QTY_W + PX_W + 1;
  localparam int SW  = (MW > PNL_W + 1) ? MW : PNL_W + 1;

  localparam logic [PNL_W-1:0] PNL_MAX = {1'b0, {(PNL_W-1){1'b1}}};
  localparam logic [PNL_W-1:0] PNL_MIN = {1'b1, {(PNL_W-1){1'b0}}};
  localparam logic [QTY_W+1:0] POS_MAX = {3'b000, {(QTY_W-1){1'b1}}};
  localparam logic [QTY_W+1:0] POS_MIN = {3'b111, {(QTY_W-2){1'b0}}, 1'b1};

  function automatic logic [PNL_W-1:0] sat_pnl(input logic [PNL_W:0] s);
    if (s[PNL_W] != s[PNL_W-1])
      return s[PNL_W] ? PNL_MIN : PNL_MAX;
    return s[PNL_W-1:0];
  endfunction

  logic             take;
  logic             s1_valid_reg, s1_side_reg;
  logic [QTY_W-1:0] s1_qty_reg;
  logic [PNL_W-1:0] s1_notional_reg, notional_next;
  logic [CW-1:0]    prod_w;
  logic [QTY_W+1:0] pos_ext, qty_ext, pos_sum;
  logic [QTY_W-1:0] position_reg, position_next;
  logic             pos_clamp;
  logic [PNL_W:0]   cash_sum, pnl_sum;
  logic [PNL_W-1:0] cash_reg, cash_next, cash_d_reg;
  logic [PX_W-1:0]  mark_reg;
  logic [SW-1:0]    mtm_full;
  logic [SW-PNL_W:0] mtm_hi;
  logic [PNL_W-1:0] mtm_reg, mtm_next;
  logic [PNL_W-1:0] pnl_reg, pnl_next, peak_reg, peak_next;
  logic [PNL_W-1:0] dd_reg, dd_next, mag_reg, mag_next;
  logic             loss_reg;
  logic [31:0]      fill_count_reg;
  logic             pos_sat_reg;

  assign feed.fill_ready = !rst && !cmd_clear;
  assign take            = feed.fill_valid && feed.fill_ready;

  // Notional clipped to PNL_W-1 bits so it is always a non-negative signed value.
  assign prod_w        = CW'(feed.fill_qty) * CW'(feed.fill_price);
  assign notional_next = (prod_w > CW'(PNL_MAX)) ? PNL_MAX : prod_w[PNL_W-1:0];

  // Two guard bits hold any signed position +/- unsigned quantity exactly.
  assign pos_ext = {{2{position_reg[QTY_W-1]}}, position_reg};
  assign qty_ext = {2'b00, s1_qty_reg};
  assign pos_sum = s1_side_reg ? (pos_ext - qty_ext) : (pos_ext + qty_ext);

  always_comb begin
    pos_clamp     = 1'b0;
    position_next = pos_sum[QTY_W-1:0];
    if ($signed(pos_sum) > $signed(POS_MAX)) begin
      pos_clamp     = 1'b1;
      position_next = POS_MAX[QTY_W-1:0];
    end else if ($signed(pos_sum) < $signed(POS_MIN)) begin
      pos_clamp     = 1'b1;
      position_next = POS_MIN[QTY_W-1:0];
    end
  end

  assign cash_sum  = s1_side_reg ? ({cash_reg[PNL_W-1], cash_reg} + {1'b0, s1_notional_reg})
                                 : ({cash_reg[PNL_W-1], cash_reg} - {1'b0, s1_notional_reg});
  assign cash_next = sat_pnl(cash_sum);

  assign mtm_full = {{(SW-QTY_W){position_reg[QTY_W-1]}}, position_reg}
                  * {{(SW-PX_W){1'b0}}, mark_reg};
  assign mtm_hi   = mtm_full[SW-1:PNL_W-1];
  assign mtm_next = (&mtm_hi || ~|mtm_hi) ? mtm_full[PNL_W-1:0]
                                          : (mtm_full[SW-1] ? PNL_MIN : PNL_MAX);

  // Cash is delayed one stage so it pairs with the mtm of the same position.
  assign pnl_sum   = {cash_d_reg[PNL_W-1], cash_d_reg} + {mtm_reg[PNL_W-1], mtm_reg};
  assign pnl_next  = sat_pnl(pnl_sum);
  assign peak_next = ($signed(pnl_next) > $signed(peak_reg)) ? pnl_next : peak_reg;
  assign dd_next   = peak_next - pnl_next;
  assign mag_next  = !pnl_next[PNL_W-1] ? pnl_next
                   : ((pnl_next == PNL_MIN) ? PNL_MAX : -pnl_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_side_reg     <= 1'b0;
      s1_qty_reg      <= '0;
      s1_notional_reg <= '0;
      position_reg    <= '0;
      cash_reg        <= '0;
      cash_d_reg      <= '0;
      mark_reg        <= '0;
      mtm_reg         <= '0;
      pnl_reg         <= '0;
      peak_reg        <= '0;
      dd_reg          <= '0;
      mag_reg         <= '0;
      loss_reg        <= 1'b0;
      fill_count_reg  <= '0;
      pos_sat_reg     <= 1'b0;
    end else begin
      if (feed.mark_valid) mark_reg <= feed.mark_price;
      if (take)            fill_count_reg <= fill_count_reg + 32'd1;
      if (cmd_clear) begin
        s1_valid_reg <= 1'b0;
        position_reg <= '0;
        cash_reg     <= '0;
        cash_d_reg   <= '0;
        mtm_reg      <= '0;
        pnl_reg      <= '0;
        peak_reg     <= '0;
        dd_reg       <= '0;
        mag_reg      <= '0;
        loss_reg     <= 1'b0;
      end else begin
        s1_valid_reg <= take;
        if (take) begin
          s1_side_reg     <= feed.fill_side;
          s1_qty_reg      <= feed.fill_qty;
          s1_notional_reg <= notional_next;
        end
        if (s1_valid_reg) begin
          position_reg <= position_next;
          cash_reg     <= cash_next;
          if (pos_clamp) pos_sat_reg <= 1'b1;
        end
        cash_d_reg <= cash_reg;
        mtm_reg    <= mtm_next;
        pnl_reg    <= pnl_next;
        peak_reg   <= peak_next;
        dd_reg     <= dd_next;
        mag_reg    <= mag_next;
        loss_reg   <= pnl_next[PNL_W-1];
      end
    end
  end

  assign current_pnl   = mag_reg;
  assign pnl_is_loss   = loss_reg;
  assign pnl_signed    = pnl_reg;
  assign drawdown      = dd_reg;
  assign position      = position_reg;
  assign fill_count    = fill_count_reg;
  assign pos_saturated = pos_sat_reg;
endmodule

// File: tb/tb_pnl_tracker.sv
// Directed-vector bench for pnl_tracker: fills, marks, drawdown, clear, clamp and reset.
module tb_pnl_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_clear = 1'b0;
  logic [63:0] current_pnl, pnl_signed, drawdown;
  logic        pnl_is_loss, pos_saturated;
  logic [31:0] position, fill_count;
  int          total = 0;
  int          bad = 0;
  int          exp_count = 0;

  always #5 clk = ~clk;

  pnl_tracker_if #(.QTY_W(32), .PX_W(32)) feed_if ();

  pnl_tracker #(.QTY_W(32), .PX_W(32), .PNL_W(64)) dut (
    .clk(clk), .rst(rst), .feed(feed_if), .cmd_clear(cmd_clear),
    .current_pnl(current_pnl), .pnl_is_loss(pnl_is_loss), .pnl_signed(pnl_signed),
    .drawdown(drawdown), .position(position), .fill_count(fill_count),
    .pos_saturated(pos_saturated)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    feed_if.fill_valid = 1'b0;
    feed_if.mark_valid = 1'b0;
    cmd_clear          = 1'b0;
  endtask

  task automatic drive_fill(input logic side, input logic [31:0] qty, input logic [31:0] px);
    feed_if.fill_valid = 1'b1;
    feed_if.fill_side  = side;
    feed_if.fill_qty   = qty;
    feed_if.fill_price = px;
    $display("fill side=%0d qty=%0d price=%0d", side, qty, px);
  endtask

  task automatic drive_mark(input logic [31:0] px);
    feed_if.mark_valid = 1'b1;
    feed_if.mark_price = px;
    $display("mark price=%0d", px);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) tick();
    total++; if (feed_if.fill_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0d want=0", feed_if.fill_ready); end
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL rst_pnl got=%0d want=0", pnl_signed); end
    total++; if (current_pnl !== 64'd0) begin bad++; $display("FAIL rst_mag got=%0d want=0", current_pnl); end
    total++; if (pnl_is_loss !== 1'b0) begin bad++; $display("FAIL rst_loss got=%0d want=0", pnl_is_loss); end
    total++; if (drawdown !== 64'd0) begin bad++; $display("FAIL rst_dd got=%0d want=0", drawdown); end
    total++; if (position !== 32'd0) begin bad++; $display("FAIL rst_pos got=%0d want=0", position); end
    total++; if (fill_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", fill_count); end
    total++; if (pos_saturated !== 1'b0) begin bad++; $display("FAIL rst_sat got=%0d want=0", pos_saturated); end
    rst = 1'b0;
    tick();
    total++; if (feed_if.fill_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0d want=1", feed_if.fill_ready); end
  endtask

  task automatic test_buy_mark();
    drive_fill(1'b0, 32'd10, 32'd100);
    drive_mark(32'd100);
    exp_count++;
    tick(); idle();
    tick();
    total++; if (position !== 32'd10) begin bad++; $display("FAIL buy_pos got=%0d want=10", position); end
    tick(); tick();
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL buy_pnl got=%0d want=0", $signed(pnl_signed)); end
    drive_mark(32'd90);
    tick(); idle();
    tick();
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL mark_early got=%0d want=0", $signed(pnl_signed)); end
    tick();
    total++; if (pnl_signed !== -64'sd100) begin bad++; $display("FAIL mark_pnl got=%0d want=-100", $signed(pnl_signed)); end
    total++; if (current_pnl !== 64'd100) begin bad++; $display("FAIL mark_mag got=%0d want=100", current_pnl); end
    total++; if (pnl_is_loss !== 1'b1) begin bad++; $display("FAIL mark_loss got=%0d want=1", pnl_is_loss); end
    total++; if (drawdown !== 64'd100) begin bad++; $display("FAIL mark_dd got=%0d want=100", drawdown); end
  endtask

  task automatic test_sell_drawdown();
    drive_fill(1'b1, 32'd10, 32'd110);
    exp_count++;
    tick(); idle();
    tick();
    total++; if (position !== 32'd0) begin bad++; $display("FAIL sell_pos got=%0d want=0", position); end
    tick(); tick();
    total++; if (pnl_signed !== 64'd100) begin bad++; $display("FAIL sell_pnl got=%0d want=100", $signed(pnl_signed)); end
    total++; if (pnl_is_loss !== 1'b0) begin bad++; $display("FAIL sell_loss got=%0d want=0", pnl_is_loss); end
    total++; if (drawdown !== 64'd0) begin bad++; $display("FAIL sell_dd got=%0d want=0", drawdown); end
    drive_fill(1'b0, 32'd5, 32'd120);
    drive_mark(32'd100);
    exp_count++;
    tick(); idle();
    repeat (3) tick();
    total++; if (position !== 32'd5) begin bad++; $display("FAIL buy5_pos got=%0d want=5", position); end
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL buy5_pnl got=%0d want=0", $signed(pnl_signed)); end
    total++; if (drawdown !== 64'd100) begin bad++; $display("FAIL buy5_dd got=%0d want=100", drawdown); end
  endtask

  task automatic test_clear();
    drive_fill(1'b0, 32'd3, 32'd100);
    exp_count++;
    tick();
    drive_fill(1'b0, 32'd4, 32'd100);
    exp_count++;
    tick();
    drive_fill(1'b0, 32'd7, 32'd100);
    cmd_clear = 1'b1;
    #1;
    total++; if (feed_if.fill_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%0d want=0", feed_if.fill_ready); end
    tick(); idle();
    #1;
    total++; if (feed_if.fill_ready !== 1'b1) begin bad++; $display("FAIL clr_ready_after got=%0d want=1", feed_if.fill_ready); end
    total++; if (position !== 32'd0) begin bad++; $display("FAIL clr_pos got=%0d want=0", position); end
    tick(); tick();
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL clr_pnl got=%0d want=0", $signed(pnl_signed)); end
    total++; if (drawdown !== 64'd0) begin bad++; $display("FAIL clr_dd got=%0d want=0", drawdown); end
    tick(); tick();
    total++; if (position !== 32'd0) begin bad++; $display("FAIL clr_pos_late got=%0d want=0", position); end
    total++; if (fill_count !== exp_count) begin bad++; $display("FAIL clr_count got=%0d want=%0d", fill_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive_fill(i[0], 32'd1, 32'd50);
      exp_count++;
      #1;
      total++; if (feed_if.fill_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%0d want=1", i, feed_if.fill_ready); end
      tick();
    end
    idle();
    repeat (5) tick();
    total++; if (fill_count !== exp_count) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", fill_count, exp_count); end
    total++; if (position !== 32'd0) begin bad++; $display("FAIL b2b_pos got=%0d want=0", position); end
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL b2b_pnl got=%0d want=0", $signed(pnl_signed)); end
    total++; if (drawdown !== 64'd50) begin bad++; $display("FAIL b2b_dd got=%0d want=50", drawdown); end
  endtask

  task automatic test_clamp();
    drive_fill(1'b0, 32'h7FFF_FFFF, 32'd1);
    exp_count++;
    tick(); idle();
    repeat (3) tick();
    total++; if (position !== 32'h7FFF_FFFF) begin bad++; $display("FAIL clamp_pos1 got=%0h want=7fffffff", position); end
    total++; if (pos_saturated !== 1'b0) begin bad++; $display("FAIL clamp_sat1 got=%0d want=0", pos_saturated); end
    drive_fill(1'b0, 32'd5, 32'd1);
    exp_count++;
    tick(); idle();
    repeat (4) tick();
    total++; if (position !== 32'h7FFF_FFFF) begin bad++; $display("FAIL clamp_pos2 got=%0h want=7fffffff", position); end
    total++; if (pos_saturated !== 1'b1) begin bad++; $display("FAIL clamp_sat2 got=%0d want=1", pos_saturated); end
    total++; if (pnl_signed !== 64'd212600881048) begin bad++; $display("FAIL clamp_pnl got=%0d want=212600881048", $signed(pnl_signed)); end
    total++; if (fill_count !== exp_count) begin bad++; $display("FAIL clamp_count got=%0d want=%0d", fill_count, exp_count); end
  endtask

  task automatic test_rst_midflight();
    drive_fill(1'b1, 32'd9, 32'd10);
    tick(); idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    total++; if (position !== 32'd0) begin bad++; $display("FAIL rstmid_pos got=%0d want=0", position); end
    total++; if (fill_count !== 32'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", fill_count); end
    total++; if (pos_saturated !== 1'b0) begin bad++; $display("FAIL rstmid_sat got=%0d want=0", pos_saturated); end
    total++; if (pnl_signed !== 64'd0) begin bad++; $display("FAIL rstmid_pnl got=%0d want=0", $signed(pnl_signed)); end
  endtask

  initial begin
    feed_if.fill_valid = 1'b0;
    feed_if.fill_side  = 1'b0;
    feed_if.fill_qty   = '0;
    feed_if.fill_price = '0;
    feed_if.mark_valid = 1'b0;
    feed_if.mark_price = '0;
    test_reset();
    test_buy_mark();
    test_sell_drawdown();
    test_clear();
    test_back_to_back();
    test_clamp();
    test_rst_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
